// File: rtl/ddr4_cmd_pkg.sv
// Shared types and constants for the DDR4 command scheduler.
//   sched_state_e : sequencer phase; each value names the command on the bus
//                   in the cycle the FSM holds that state.
//   CMD_*         : A[16:14] RAS/CAS/WE encodings for WR, RD and PRE.
//   AP_BIT        : A[10], auto-precharge / all-bank select (always 0 here).
//   CNT_W         : width of the internal wait and tRAS counters.
package ddr4_cmd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_RP,
    S_ACT,
    S_WAIT_RCD,
    S_CAS,
    S_DATA
  } sched_state_e;

  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_PRE = 3'b010;

  localparam int AP_BIT = 10;
  localparam int CNT_W  = 8;

endpackage

// File: rtl/bank_state_table.sv
// Open-row table: one {open, row} entry per bank, indexed {bg, ba}.
//   gclk/grst_n      : clock, async active-low reset (clears every open flag)
//   lk_idx/lk_row    : lookup bank and row
//   lk_open/lk_hit   : bank is open / open with the same row
//   set_en/idx/row   : mark a bank open with a row (ACT)
//   clr_en/clr_idx   : mark a bank closed (PRE)
module bank_state_table #(
  parameter int NBANKS = 16,
  parameter int IDXW   = 4,
  parameter int ROWW   = 17
) (
  input  logic            gclk,
  input  logic            grst_n,
  input  logic [IDXW-1:0] lk_idx,
  input  logic [ROWW-1:0] lk_row,
  output logic            lk_open,
  output logic            lk_hit,
  input  logic            set_en,
  input  logic [IDXW-1:0] set_idx,
  input  logic [ROWW-1:0] set_row,
  input  logic            clr_en,
  input  logic [IDXW-1:0] clr_idx
);

  logic [NBANKS-1:0]           open_q;
  logic [NBANKS-1:0][ROWW-1:0] row_q;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      open_q <= '0;
      row_q  <= '0;
    end else begin
      if (clr_en) open_q[clr_idx] <= 1'b0;
      if (set_en) begin
        open_q[set_idx] <= 1'b1;
        row_q[set_idx]  <= set_row;
      end
    end
  end

  assign lk_open = open_q[lk_idx];
  assign lk_hit  = lk_open && (row_q[lk_idx] == lk_row);

endmodule

// File: rtl/ddr4_cmd_scheduler.sv
// Single-channel DDR4 command sequencer, open-page policy, one request at a time.
//   ck_t/reset_n        : clock, async active-low reset
//   req_*               : request handshake and fields (we, bg, ba, row, col)
//   cs_n/act_n/A/bg/ba  : registered command bus (DES/ACT/RD/WR/PRE)
//   wr_en/rd_valid      : per-beat data-window strobes
//   resp_valid          : pulse with the last beat of each burst
// The FSM state names the command on the bus in the same cycle: the command
// registers load the decode of the next state, so a request accepted in
// cycle n drives its first command in cycle n+1.
module ddr4_cmd_scheduler
  import ddr4_cmd_pkg::*;
#(
  parameter  int ADDRWIDTH     = 17,
  parameter  int BANKGROUPS    = 4,
  parameter  int BANKSPERGROUP = 4,
  parameter  int COLS          = 1024,
  parameter  int BL            = 8,
  parameter  int TRCD          = 15,
  parameter  int TCL           = 15,
  parameter  int TCWL          = 11,
  parameter  int TRP           = 15,
  parameter  int TRAS          = 32,
  localparam int BGWIDTH       = $clog2(BANKGROUPS),
  localparam int BAWIDTH       = $clog2(BANKSPERGROUP),
  localparam int CADDRWIDTH    = $clog2(COLS),
  localparam int NBANKS        = BANKGROUPS * BANKSPERGROUP
) (
  input  logic                  ck_t,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [BGWIDTH-1:0]    req_bg,
  input  logic [BAWIDTH-1:0]    req_ba,
  input  logic [ADDRWIDTH-1:0]  req_row,
  input  logic [CADDRWIDTH-1:0] req_col,
  output logic                  cs_n,
  output logic                  act_n,
  output logic [ADDRWIDTH-1:0]  A,
  output logic [BGWIDTH-1:0]    bg,
  output logic [BAWIDTH-1:0]    ba,
  output logic                  wr_en,
  output logic                  rd_valid,
  output logic                  resp_valid
);

  sched_state_e           state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d, ras_cnt, ras_d;
  logic                   lat_we;
  logic [BGWIDTH-1:0]     lat_bg;
  logic [BAWIDTH-1:0]     lat_ba;
  logic [ADDRWIDTH-1:0]   lat_row;
  logic [CADDRWIDTH-1:0]  lat_col;
  logic                   accept, lk_open, lk_hit, ras_done;
  logic [CNT_W-1:0]       data_lat, data_last;
  logic                   f_we;
  logic [BGWIDTH-1:0]     f_bg;
  logic [BAWIDTH-1:0]     f_ba;
  logic [ADDRWIDTH-1:0]   f_row;
  logic [CADDRWIDTH-1:0]  f_col;
  logic                   cs_d, act_d;
  logic [ADDRWIDTH-1:0]   a_d;
  logic [BGWIDTH-1:0]     bg_d;
  logic [BAWIDTH-1:0]     ba_d;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign ras_done  = (ras_cnt == CNT_W'(TRAS));

  // Fields as they will be after this edge: the command decoded on the
  // accepting edge must already see the incoming request.
  assign f_we  = accept ? req_we  : lat_we;
  assign f_bg  = accept ? req_bg  : lat_bg;
  assign f_ba  = accept ? req_ba  : lat_ba;
  assign f_row = accept ? req_row : lat_row;
  assign f_col = accept ? req_col : lat_col;

  // DATA counts from 0 in the cycle after CAS; first beat lands on lat-1.
  assign data_lat  = lat_we ? CNT_W'(TCWL) : CNT_W'(TCL);
  assign data_last = data_lat + CNT_W'(BL - 2);

  bank_state_table #(
    .NBANKS (NBANKS),
    .IDXW   (BGWIDTH + BAWIDTH),
    .ROWW   (ADDRWIDTH)
  ) u_banks (
    .gclk    (ck_t),
    .grst_n  (reset_n),
    .lk_idx  ({req_bg, req_ba}),
    .lk_row  (req_row),
    .lk_open (lk_open),
    .lk_hit  (lk_hit),
    .set_en  (state == S_ACT),
    .set_idx ({lat_bg, lat_ba}),
    .set_row (lat_row),
    .clr_en  (state == S_PRE && ras_done),
    .clr_idx ({lat_bg, lat_ba})
  );

  // State register, counters, request latch.
  always_ff @(posedge ck_t or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ras_cnt <= '0;
      lat_we  <= 1'b0;
      lat_bg  <= '0;
      lat_ba  <= '0;
      lat_row <= '0;
      lat_col <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      ras_cnt <= ras_d;
      if (accept) begin
        lat_we  <= req_we;
        lat_bg  <= req_bg;
        lat_ba  <= req_ba;
        lat_row <= req_row;
        lat_col <= req_col;
      end
    end
  end

  // Next state. Wait states run for T-1 cycles so the following command
  // lands exactly T cycles after the one that started the wait.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_IDLE: if (accept) begin
        cnt_d = '0;
        if (lk_hit)       state_d = S_CAS;
        else if (lk_open) state_d = S_PRE;
        else              state_d = S_ACT;
      end
      S_PRE: if (ras_done) begin
        state_d = S_WAIT_RP;
        cnt_d   = CNT_W'(TRP - 2);
      end
      S_WAIT_RP: begin
        if (cnt == '0) state_d = S_ACT;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      S_ACT: begin
        state_d = S_WAIT_RCD;
        cnt_d   = CNT_W'(TRCD - 2);
      end
      S_WAIT_RCD: begin
        if (cnt == '0) state_d = S_CAS;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      S_CAS: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        if (cnt == data_last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Cycles since the most recent ACT on any bank, saturating at TRAS.
  assign ras_d = (state_d == S_ACT) ? '0 :
                 (ras_cnt == CNT_W'(TRAS)) ? ras_cnt : ras_cnt + CNT_W'(1);

  // Outputs: command decode of the next state, beat strobes of the current.
  always_comb begin
    cs_d  = 1'b1;
    act_d = 1'b1;
    a_d   = '0;
    bg_d  = bg;
    ba_d  = ba;
    case (state_d)
      S_ACT: begin
        cs_d  = 1'b0;
        act_d = 1'b0;
        a_d   = f_row;
        bg_d  = f_bg;
        ba_d  = f_ba;
      end
      S_CAS: begin
        cs_d                    = 1'b0;
        a_d[ADDRWIDTH-1 -: 3]   = f_we ? CMD_WR : CMD_RD;
        a_d[CADDRWIDTH-1:0]     = f_col;
        a_d[AP_BIT]             = 1'b0;
        bg_d                    = f_bg;
        ba_d                    = f_ba;
      end
      S_PRE: if (ras_d == CNT_W'(TRAS)) begin
        cs_d                  = 1'b0;
        a_d[ADDRWIDTH-1 -: 3] = CMD_PRE;
        a_d[AP_BIT]           = 1'b0;
        bg_d                  = f_bg;
        ba_d                  = f_ba;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_en      = 1'b0;
    rd_valid   = 1'b0;
    resp_valid = 1'b0;
    if (state == S_DATA && cnt >= data_lat - CNT_W'(1)) begin
      wr_en      = lat_we;
      rd_valid   = !lat_we;
      resp_valid = (cnt == data_last);
    end
  end

  always_ff @(posedge ck_t or negedge reset_n) begin
    if (!reset_n) begin
      cs_n  <= 1'b1;
      act_n <= 1'b1;
      A     <= '0;
      bg    <= '0;
      ba    <= '0;
    end else begin
      cs_n  <= cs_d;
      act_n <= act_d;
      A     <= a_d;
      bg    <= bg_d;
      ba    <= ba_d;
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Scoreboard bench for ddr4_cmd_scheduler. A timing model computes the
// absolute cycle of every command and data beat from the DDR4 rules;
// a monitor pops and compares whenever the bus shows a command or a beat.
module tb_ddr4_cmd_scheduler;

  localparam int TRCD = 15, TCL = 15, TCWL = 11, TRP = 15, TRAS = 32, BL = 8;
  localparam int K_ACT = 0, K_CAS = 1, K_PRE = 2, K_BEAT = 3;

  logic        ck_t = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [1:0]  req_bg = '0, req_ba = '0;
  logic [16:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        cs_n, act_n, wr_en, rd_valid, resp_valid;
  logic [16:0] A;
  logic [1:0]  bg, ba;

  ddr4_cmd_scheduler dut (
    .ck_t(ck_t), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_col(req_col), .cs_n(cs_n), .act_n(act_n), .A(A), .bg(bg), .ba(ba),
    .wr_en(wr_en), .rd_valid(rd_valid), .resp_valid(resp_valid)
  );

  always #5 ck_t = ~ck_t;

  int cyc = 0;
  always @(posedge ck_t) cyc++;

  typedef struct {
    int          cyc;
    int          kind;
    logic [16:0] a;
    logic [1:0]  bg, ba;
    bit          we, last;
  } ev_t;

  ev_t         expq[$];
  int          tests = 0, fails = 0;
  bit          m_open[16];
  logic [16:0] m_row[16];
  int          last_act = -1000;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int k, input logic [16:0] a,
                      input logic [1:0] g, input logic [1:0] b, input bit we, input bit last);
    ev_t e;
    e.cyc = c; e.kind = k; e.a = a; e.bg = g; e.ba = b; e.we = we; e.last = last;
    expq.push_back(e);
  endtask

  // Reference timing: every command is placed at its earliest legal cycle.
  task automatic model_req(input int acc, input bit we, input logic [1:0] g, input logic [1:0] b,
                           input logic [16:0] row, input logic [9:0] col, output int ready_cyc);
    int t, idx, act, cas, pre, first;
    logic [16:0] a;
    t   = acc + 1;
    idx = int'({g, b});
    if (m_open[idx] && m_row[idx] == row) begin
      cas = t;
    end else begin
      if (m_open[idx]) begin
        pre = (t > last_act + TRAS) ? t : last_act + TRAS;
        push(pre, K_PRE, 17'h08000, g, b, 1'b0, 1'b0);
        act = pre + TRP;
      end else begin
        act = t;
      end
      push(act, K_ACT, row, g, b, 1'b0, 1'b0);
      last_act    = act;
      m_open[idx] = 1'b1;
      m_row[idx]  = row;
      cas = act + TRCD;
    end
    a = '0;
    a[16:14] = we ? 3'b100 : 3'b101;
    a[9:0]   = col;
    push(cas, K_CAS, a, g, b, we, 1'b0);
    first = cas + (we ? TCWL : TCL);
    for (int k = 0; k < BL; k++) push(first + k, K_BEAT, '0, g, b, we, k == BL - 1);
    ready_cyc = first + BL;
  endtask

  // Monitor: sample on the falling edge, compare against the queue head.
  always @(negedge ck_t) begin
    ev_t e;
    if (reset_n) begin
      while (expq.size() > 0 && expq[0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL missing_event: kind %0d expected at cycle %0d, absent at cycle %0d",
                 expq[0].kind, expq[0].cyc, cyc);
        void'(expq.pop_front());
      end
      if (!cs_n) begin
        if (expq.size() == 0 || expq[0].cyc != cyc || expq[0].kind == K_BEAT) begin
          tests++; fails++;
          $display("FAIL unexpected_cmd: act_n=%b A=%h bg=%0d ba=%0d at cycle %0d, none required",
                   act_n, A, bg, ba, cyc);
        end else begin
          e = expq.pop_front();
          chk("cmd_act_n", {31'd0, act_n}, (e.kind == K_ACT) ? 32'd0 : 32'd1);
          chk("cmd_A", {15'd0, A}, {15'd0, e.a});
          chk("cmd_bgba", {28'd0, bg, ba}, {28'd0, e.bg, e.ba});
        end
      end else begin
        chk("des_bus", {14'd0, act_n, A}, {14'd0, 1'b1, 17'd0});
      end
      if (wr_en || rd_valid || resp_valid) begin
        if (expq.size() == 0 || expq[0].cyc != cyc || expq[0].kind != K_BEAT) begin
          tests++; fails++;
          $display("FAIL unexpected_beat: wr_en=%b rd_valid=%b resp_valid=%b at cycle %0d, none required",
                   wr_en, rd_valid, resp_valid, cyc);
        end else begin
          e = expq.pop_front();
          chk("beat_strobes", {29'd0, wr_en, rd_valid, resp_valid},
              {29'd0, e.we, !e.we, e.last});
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs_n"}, {31'd0, cs_n}, 32'd1);
    chk({tag, "_act_n"}, {31'd0, act_n}, 32'd1);
    chk({tag, "_A"}, {15'd0, A}, 32'd0);
    chk({tag, "_bgba"}, {28'd0, bg, ba}, 32'd0);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_strobes"}, {29'd0, wr_en, rd_valid, resp_valid}, 32'd0);
  endtask

  // Called #1 after a falling edge with the DUT idle; returns after accept.
  task automatic issue(input bit we, input logic [1:0] g, input logic [1:0] b,
                       input logic [16:0] row, input logic [9:0] col, input bit hold,
                       output int ready_cyc);
    chk("ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_bg = g; req_ba = b; req_row = row; req_col = col;
    model_req(cyc, we, g, b, row, col, ready_cyc);
    @(posedge ck_t); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  // With hold set, keeps req_valid high and scrambles fields while busy.
  task automatic wait_ready(input int exp_cyc, input bit hold);
    int n;
    n = 0;
    forever begin
      @(negedge ck_t); #1;
      if (req_ready) break;
      if (hold) begin
        req_we  = 1'($urandom);
        req_bg  = 2'($urandom);
        req_ba  = 2'($urandom);
        req_row = 17'($urandom);
        req_col = 10'($urandom);
      end
      n++;
      if (n > 600) begin
        tests++; fails++;
        $display("FAIL ready_timeout: req_ready low for 600 cycles, expected high at cycle %0d", exp_cyc);
        req_valid = 1'b0;
        return;
      end
    end
    req_valid = 1'b0;
    chk("ready_cycle", cyc, exp_cyc);
  endtask

  task automatic run_req(input bit we, input logic [1:0] g, input logic [1:0] b,
                         input logic [16:0] row, input logic [9:0] col, input bit hold);
    int rc;
    issue(we, g, b, row, col, hold, rc);
    wait_ready(rc, hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    logic [16:0] rows[16];
    repeat (3) @(negedge ck_t);
    #1 chk_reset_outputs("reset");
    #1 reset_n = 1'b1;
    @(negedge ck_t); #1;

    // Closed-bank read, row hit write, row conflict read.
    run_req(1'b0, 2'd1, 2'd1, 17'd1, 10'd0, 1'b0);
    run_req(1'b1, 2'd1, 2'd1, 17'd1, 10'd8, 1'b0);
    run_req(1'b0, 2'd1, 2'd1, 17'd2, 10'd16, 1'b0);

    // Busy: req_valid held with changing fields, only the first is sequenced.
    run_req(1'b1, 2'd2, 2'd3, 17'h1abcd, 10'h3f8, 1'b1);

    // Reset during the data phase of a read (row hit on bank 1/1).
    issue(1'b0, 2'd1, 2'd1, 17'd2, 10'd24, 1'b0, rc);
    repeat (6) @(negedge ck_t);
    #2 reset_n = 1'b0;
    expq.delete();
    foreach (m_open[i]) m_open[i] = 1'b0;
    last_act = -1000;
    #1 chk_reset_outputs("midburst");
    @(negedge ck_t); #2 reset_n = 1'b1;
    @(negedge ck_t); #1;
    run_req(1'b0, 2'd1, 2'd1, 17'd2, 10'd24, 1'b0);

    // One request per bank, then repeat the same rows (all hits).
    foreach (rows[i]) rows[i] = 17'($urandom);
    rows[5] = 17'd2;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 16; i++)
        run_req(1'($urandom), 2'(i >> 2), 2'(i), rows[i], 10'($urandom), 1'b0);

    // Random traffic over a few rows for a mix of hits, misses and conflicts.
    for (int i = 0; i < 40; i++)
      run_req(1'($urandom), 2'($urandom), 2'($urandom), 17'($urandom_range(0, 3)),
              10'($urandom), ($urandom_range(0, 3) == 0));

    repeat (5) @(negedge ck_t); #1;
    chk("queue_drained", expq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
